lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameters: none; all data/address widths SHALL be `WORD_LEN` (32) from consts.vh.
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  1  pipeline access request, sampled only while busy=0.
REQ-005 we  input  1  1=store, 0=load; sampled with req.
REQ-006 funct3  input  3  [1:0] size (00 byte, 01 half, 1x word); [2] unsigned load.
REQ-007 addr  input  WORD_LEN  byte address of access.
REQ-008 wdata_in  input  WORD_LEN  store data, right-aligned.
REQ-009 busy  output  1  high in every non-IDLE state.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 rdata_out  output  WORD_LEN  extended load result, valid while done=1, held until next load completes.
REQ-012 err  output  1  misalignment flag, qualified by done.
REQ-013 addr_d  output  WORD_LEN  data-memory byte address (memory indexes addr_d[31:2]).
REQ-014 rdata  input  WORD_LEN  memory read word, valid the cycle after addr_d is presented.
REQ-015 wen  output  1  memory write enable; memory writes on the rising edge where wen=1.
REQ-016 wdata  output  WORD_LEN  full word to memory (no byte enables exist).

Function
REQ-017 States SHALL be IDLE, RD_ISSUE, RD_CAPTURE, WR, RESP.
REQ-018 IDLE & req: latch addr/funct3/we/wdata_in; load or sub-word store -> RD_ISSUE; word store -> WR.
REQ-019 RD_ISSUE: addr_d = {latched addr[31:2],2'b00}; -> RD_CAPTURE next edge.
REQ-020 RD_CAPTURE, load: byte/half lane extracted from rdata, sign- or zero-extended per funct3[2], registered into rdata_out; -> RESP.
REQ-021 RD_CAPTURE, sub-word store: merged word registered (rdata with target lane replaced by wdata_in low bits); -> WR.
REQ-022 Byte lane k = addr[1:0] occupies bits [8k+7:8k]; half lane h = addr[1] occupies [16h+15:16h].
REQ-023 WR: wen=1 for exactly one cycle, wdata = merged word (sub-word) or latched wdata_in (word); -> RESP.
REQ-024 RESP: done=1 for one cycle; -> IDLE; req ignored in RESP.
REQ-025 Latency from accepting edge to first edge with done=1: load 3, word store 2, sub-word store 4 cycles.
REQ-026 wen SHALL be 0 in every state except WR; req while busy=1 SHALL be ignored with no side effect.
REQ-027 Stores SHALL leave rdata_out unchanged; err=0 on every aligned access.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, wen=0, done=0, busy=0, err=0, rdata_out=0, addr_d=0, wdata=0.
REQ-029 Reset during RD_CAPTURE or WR SHALL abort with no memory write at any later edge.

Configuration
REQ-030 Macro MISALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL skip memory entirely (IDLE -> RESP), pulse done with err=1, leave rdata_out and memory unchanged.
REQ-031 Macro undefined: err tied 0; word accesses ignore addr[1:0], half accesses ignore addr[0].

Verification
REQ-032 mem[1]=0x8899AABB; LB addr=0x5 -> done 3 cycles after accept, rdata_out=0xFFFFFFAA.
REQ-033 Same word; LHU addr=0x6 -> rdata_out=0x00008899; LH addr=0x4 -> 0xFFFFAABB.
REQ-034 SW addr=0x8 wdata_in=0x12345678 -> single wen pulse, mem[2]=0x12345678, done 2 cycles after accept.
REQ-035 mem[1]=0x8899AABB; SB addr=0x6 wdata_in=0x000000CC -> mem[1]=0x88CCAABB, done after 4 cycles, exactly one wen pulse.
REQ-036 SH addr=0x4 wdata_in=0xBEEF, rst_n=0 during RD_CAPTURE -> wen never asserted, mem[1] unchanged, all outputs 0.
REQ-037 With MISALIGN_CHECK_EN: LW addr=0x3 -> done+err=1 one cycle after accept, no wen, rdata_out unchanged; without it: LW addr=0x3 returns mem[0].

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: byte/half/word accesses to a word-wide data memory without byte enables.
// Define MISALIGN_CHECK_EN to reject misaligned half/word accesses with err instead of truncating the address.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module lsu (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 we,
    input  logic [2:0]           funct3,
    input  logic [`WORD_LEN-1:0] addr,
    input  logic [`WORD_LEN-1:0] wdata_in,
    output logic                 busy,
    output logic                 done,
    output logic [`WORD_LEN-1:0] rdata_out,
    output logic                 err,
    output logic [`WORD_LEN-1:0] addr_d,
    input  logic [`WORD_LEN-1:0] rdata,
    output logic                 wen,
    output logic [`WORD_LEN-1:0] wdata
);
    localparam int W = `WORD_LEN;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_ISSUE   = 3'd1,
        RD_CAPTURE = 3'd2,
        WR         = 3'd3,
        RESP       = 3'd4
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] acc_addr_q, acc_addr_d;
    logic [2:0]   funct3_q, funct3_d;
    logic         we_q, we_d;
    logic [W-1:0] store_word_q, store_word_d;  // latched store data, later the merged word
    logic [W-1:0] rdata_out_q, rdata_out_d;
    logic         misalign;
    logic [7:0]   lane_b;
    logic [15:0]  lane_h;
    logic [W-1:0] load_ext, merged;

`ifdef MISALIGN_CHECK_EN
    logic err_q, err_d;
    assign misalign = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1] && addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Lane extraction and read-modify-write merge, both keyed by the latched access.
    always_comb begin
        unique case (acc_addr_q[1:0])
            2'd0: lane_b = rdata[7:0];
            2'd1: lane_b = rdata[15:8];
            2'd2: lane_b = rdata[23:16];
            2'd3: lane_b = rdata[31:24];
        endcase
        lane_h = acc_addr_q[1] ? rdata[31:16] : rdata[15:0];

        load_ext = rdata;
        if (funct3_q[1:0] == 2'b00)
            load_ext = {{(W-8){lane_b[7] & ~funct3_q[2]}}, lane_b};
        else if (funct3_q[1:0] == 2'b01)
            load_ext = {{(W-16){lane_h[15] & ~funct3_q[2]}}, lane_h};

        merged = rdata;
        if (funct3_q[1:0] == 2'b00) begin
            unique case (acc_addr_q[1:0])
                2'd0: merged[7:0]   = store_word_q[7:0];
                2'd1: merged[15:8]  = store_word_q[7:0];
                2'd2: merged[23:16] = store_word_q[7:0];
                2'd3: merged[31:24] = store_word_q[7:0];
            endcase
        end else if (acc_addr_q[1]) begin
            merged[31:16] = store_word_q[15:0];
        end else begin
            merged[15:0]  = store_word_q[15:0];
        end
    end

    // NOTE: every variable gets a hold default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        acc_addr_d   = acc_addr_q;
        funct3_d     = funct3_q;
        we_d         = we_q;
        store_word_d = store_word_q;
        rdata_out_d  = rdata_out_q;
`ifdef MISALIGN_CHECK_EN
        err_d        = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    acc_addr_d = addr;
                    funct3_d   = funct3;
                    we_d       = we;
                    if (we) store_word_d = wdata_in;
`ifdef MISALIGN_CHECK_EN
                    err_d      = misalign;
`endif
                    if (misalign)
                        state_d = RESP;
                    else if (we && funct3[1])
                        state_d = WR;
                    else
                        state_d = RD_ISSUE;
                end
            end
            RD_ISSUE:   state_d = RD_CAPTURE;
            RD_CAPTURE: begin
                if (we_q) begin
                    store_word_d = merged;
                    state_d      = WR;
                end else begin
                    rdata_out_d  = load_ext;
                    state_d      = RESP;
                end
            end
            WR:         state_d = RESP;
            RESP:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_addr_q   <= '0;
            funct3_q     <= '0;
            we_q         <= 1'b0;
            store_word_q <= '0;
            rdata_out_q  <= '0;
`ifdef MISALIGN_CHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            acc_addr_q   <= acc_addr_d;
            funct3_q     <= funct3_d;
            we_q         <= we_d;
            store_word_q <= store_word_d;
            rdata_out_q  <= rdata_out_d;
`ifdef MISALIGN_CHECK_EN
            err_q        <= err_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == RESP);
    assign wen       = (state_q == WR);
    assign addr_d    = {acc_addr_q[W-1:2], 2'b00};
    assign wdata     = store_word_q;
    assign rdata_out = rdata_out_q;
`ifdef MISALIGN_CHECK_EN
    assign err       = done & err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: word-level memory model, per-cycle output checks, literal anchors.
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0, we = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, wdata_in = '0;
    logic        busy, done, err, wen;
    logic [31:0] rdata_out, addr_d, wdata;
    logic [31:0] rdata = '0;

    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    int wen_count = 0;
    int exp_wen_total = 0;
    int n_tests = 0, n_fail = 0;

    // current operation as seen by the checker
    bit          active = 1'b0;
    int          k = 0, op_L = 0;
    bit          op_err, op_wr, op_upd, op_mem;
    logic [2:0]  op_f3;
    logic [31:0] op_addr, op_wd, op_new;
    logic [31:0] cur_rdata = '0;

    lsu dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .funct3(funct3), .addr(addr),
        .wdata_in(wdata_in), .busy(busy), .done(done), .rdata_out(rdata_out), .err(err),
        .addr_d(addr_d), .rdata(rdata), .wen(wen), .wdata(wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rdata <= mem[addr_d[5:2]];
        if (wen) begin
            mem[addr_d[5:2]] = wdata;
            wen_count = wen_count + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [31:0] a);
        logic [31:0] v;
        if (f3[1:0] == 2'b00) begin
            v = (word >> (8 * int'(a[1:0]))) & 32'hFF;
            if (!f3[2] && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (f3[1:0] == 2'b01) begin
            v = (word >> (16 * int'(a[1]))) & 32'hFFFF;
            if (!f3[2] && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [2:0] f3,
                                                input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        if (f3[1]) return wd;
        mask = (f3[1:0] == 2'b00) ? 32'hFF : 32'hFFFF;
        sh   = (f3[1:0] == 2'b00) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
        return (old & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    function automatic bit model_misalign(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_CHECK_EN
        return (f3[1:0] == 2'b01 && (a % 2) != 0) || (f3[1] && (a % 4) != 0);
`else
        return 1'b0 & f3[0] & a[0];
`endif
    endfunction

    // Per-cycle compare against the latency/result model.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst busy", busy, 0);
            check("rst done", done, 0);
            check("rst wen", wen, 0);
            check("rst rdata_out", rdata_out, 0);
        end else begin
            if (active) k = k + 1;
            check("busy", busy, active);
            check("done", done, active && k == op_L);
            check("wen", wen, active && op_wr && k == op_L - 1);
            check("err", err, active && op_err && k == op_L);
            check("rdata_out", rdata_out, (active && op_upd && k >= op_L) ? op_new : cur_rdata);
            if (active && op_mem && k == 1)
                check("addr_d", addr_d, {op_addr[31:2], 2'b00});
            if (active && op_wr && k == op_L - 1)
                check("wdata", wdata, model_store(ref_mem[op_addr[5:2]], op_f3, op_addr, op_wd));
        end
    end

    task automatic start_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd);
        op_err  = model_misalign(f3, a);
        op_addr = a;
        op_f3   = f3;
        op_wd   = wd;
        op_mem  = !op_err;
        op_wr   = w && !op_err;
        op_upd  = !w && !op_err;
        if (op_err)          op_L = 1;
        else if (w && f3[1]) op_L = 2;
        else if (w)          op_L = 4;
        else                 op_L = 3;
        if (op_upd) op_new = model_load(ref_mem[a[5:2]], f3, a);
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata_in = wd;
        @(posedge clk);
        k = 0;
        active = 1'b1;
        #1;
        // a competing word store held high while busy must have no effect
        we = 1'b1; funct3 = 3'b010; addr = 32'h0000_000C; wdata_in = 32'hDEAD_BEEF;
    endtask

    task automatic run_op(input string name, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        start_op(w, f3, a, wd);
        repeat (op_L) @(negedge clk);
        @(posedge clk);  // RESP -> IDLE edge, req still high and ignored
        #1;
        req = 1'b0;
        active = 1'b0;
        if (op_upd) cur_rdata = op_new;
        if (op_wr) begin
            ref_mem[a[5:2]] = model_store(ref_mem[a[5:2]], f3, a, wd);
            exp_wen_total++;
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s mem[%0d]", name, i), mem[i], ref_mem[i]);
        check({name, " wen count"}, wen_count, exp_wen_total);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h1122_3344;
        mem[1] = 32'h8899_AABB;
        mem[3] = 32'hCAFE_F00D;
        for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];

        #2 rst_n = 1'b0;
        #1;
        check("reset busy", busy, 0);
        check("reset addr_d", addr_d, 0);
        check("reset wdata", wdata, 0);
        check("reset err", err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("LB 5", 1'b0, 3'b000, 32'h5, 32'h0);
        check("LB 5 literal", rdata_out, 32'hFFFF_FFAA);
        run_op("LHU 6", 1'b0, 3'b101, 32'h6, 32'h0);
        check("LHU 6 literal", rdata_out, 32'h0000_8899);
        run_op("LH 4", 1'b0, 3'b001, 32'h4, 32'h0);
        check("LH 4 literal", rdata_out, 32'hFFFF_AABB);
        run_op("LBU 7", 1'b0, 3'b100, 32'h7, 32'h0);
        check("LBU 7 literal", rdata_out, 32'h0000_0088);
        run_op("LW C", 1'b0, 3'b010, 32'hC, 32'h0);
        check("LW C literal", rdata_out, 32'hCAFE_F00D);
        run_op("SW 8", 1'b1, 3'b010, 32'h8, 32'h1234_5678);
        check("SW 8 literal", mem[2], 32'h1234_5678);
        check("SW keeps rdata_out", rdata_out, 32'hCAFE_F00D);
        run_op("SB 6", 1'b1, 3'b000, 32'h6, 32'h0000_00CC);
        check("SB 6 literal", mem[1], 32'h88CC_AABB);
        run_op("SH A", 1'b1, 3'b001, 32'hA, 32'hFFFF_BEEF);
        check("SH A literal", mem[2], 32'hBEEF_5678);
        run_op("SB 0", 1'b1, 3'b000, 32'h0, 32'h1234_56A5);
        check("SB 0 literal", mem[0], 32'h1122_33A5);
        run_op("LB 8", 1'b0, 3'b000, 32'h8, 32'h0);
        check("LB 8 literal", rdata_out, 32'h0000_0078);

        run_op("LW 3", 1'b0, 3'b010, 32'h3, 32'h0);
`ifdef MISALIGN_CHECK_EN
        check("LW 3 literal", rdata_out, 32'h0000_0078);
`else
        check("LW 3 literal", rdata_out, 32'h1122_33A5);
`endif
        run_op("LH 5", 1'b0, 3'b001, 32'h5, 32'h0);
`ifdef MISALIGN_CHECK_EN
        check("LH 5 literal", rdata_out, 32'h0000_0078);
`else
        check("LH 5 literal", rdata_out, 32'hFFFF_AABB);
`endif
        run_op("SW D", 1'b1, 3'b010, 32'hD, 32'h0BAD_F00D);

        // Reset while the sub-word store sits in RD_CAPTURE.
        start_op(1'b1, 3'b001, 32'h4, 32'h0000_BEEF);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b0;
        req = 1'b0;
        active = 1'b0;
        cur_rdata = '0;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort wen", wen, 0);
        check("abort err", err, 0);
        check("abort rdata_out", rdata_out, 0);
        check("abort addr_d", addr_d, 0);
        check("abort wdata", wdata, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort wen count", wen_count, exp_wen_total);
        check("abort mem[1] literal", mem[1], 32'h88CC_AABB);

        run_op("LW 4 after abort", 1'b0, 3'b010, 32'h4, 32'h0);
        check("LW 4 literal", rdata_out, 32'h88CC_AABB);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
